// File: rtl/ahb_slave_pkg.sv
// Shared constants for the AHB slave interface of the AHB-to-APB bridge:
// transfer codes, response code, address map and peripheral select codes.
package ahb_slave_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [1:0] HRESP_OKAY = 2'b00;

    // Three 64 MB peripheral windows, back to back from 0x8000_0000.
    localparam logic [31:0] ADDR_PERIPH0 = 32'h8000_0000;
    localparam logic [31:0] ADDR_PERIPH1 = 32'h8400_0000;
    localparam logic [31:0] ADDR_PERIPH2 = 32'h8800_0000;
    localparam logic [31:0] ADDR_END     = 32'h8C00_0000;

    localparam logic [2:0] SEL_NONE    = 3'b000;
    localparam logic [2:0] SEL_PERIPH0 = 3'b001;
    localparam logic [2:0] SEL_PERIPH1 = 3'b010;
    localparam logic [2:0] SEL_PERIPH2 = 3'b100;

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational address decode: one-hot peripheral select from the address
// alone, and transfer qualification for the bridge window.
module ahb_addr_decode
    import ahb_slave_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hreadyin,
    output logic              valid,
    output logic [2:0]        tempselx
);

    logic in_window;
    logic active_trans;

    assign in_window    = (haddr >= ADDR_W'(ADDR_PERIPH0)) && (haddr < ADDR_W'(ADDR_END));
    assign active_trans = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    assign valid        = hreadyin && active_trans && in_window;

    always_comb begin
        // NOTE: default first so every path assigns tempselx; no latch is inferred.
        tempselx = SEL_NONE;
        if (haddr >= ADDR_W'(ADDR_PERIPH0) && haddr < ADDR_W'(ADDR_PERIPH1))
            tempselx = SEL_PERIPH0;
        else if (haddr >= ADDR_W'(ADDR_PERIPH1) && haddr < ADDR_W'(ADDR_PERIPH2))
            tempselx = SEL_PERIPH1;
        else if (haddr >= ADDR_W'(ADDR_PERIPH2) && haddr < ADDR_W'(ADDR_END))
            tempselx = SEL_PERIPH2;
    end

endmodule

// File: rtl/ahb_slave.sv
// AHB slave front end of the AHB-to-APB bridge: free-running address/data
// pipeline, address decode, read-data passthrough and an always-OKAY response.
module ahb_slave
    import ahb_slave_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              Hwrite,
    input  logic              Hreadyin,
    input  logic [1:0]        Htrans,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [DATA_W-1:0] Prdata,
    output logic              valid,
    output logic [ADDR_W-1:0] Haddr1,
    output logic [ADDR_W-1:0] Haddr2,
    output logic [DATA_W-1:0] Hwdata1,
    output logic [DATA_W-1:0] Hwdata2,
    output logic [DATA_W-1:0] Hrdata,
    output logic              Hwritereg,
    output logic [2:0]        tempselx,
    output logic [1:0]        Hresp
);

    ahb_addr_decode #(
        .ADDR_W (ADDR_W)
    ) u_decode (
        .haddr    (Haddr),
        .htrans   (Htrans),
        .hreadyin (Hreadyin),
        .valid    (valid),
        .tempselx (tempselx)
    );

    // The pipeline never stalls: the APB side relies on fixed 1- and 2-cycle latency.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            Haddr1    <= '0;
            Haddr2    <= '0;
            Hwdata1   <= '0;
            Hwdata2   <= '0;
            Hwritereg <= 1'b0;
        end else begin
            // NOTE: non-blocking so Haddr2 takes the old Haddr1, forming a true two-stage delay.
            Haddr1    <= Haddr;
            Haddr2    <= Haddr1;
            Hwdata1   <= Hwdata;
            Hwdata2   <= Hwdata1;
            Hwritereg <= Hwrite;
        end
    end

    assign Hrdata = Prdata;
    assign Hresp  = HRESP_OKAY;

endmodule

// File: tb/tb_ahb_slave.sv
// Self-checking bench for ahb_slave: a history-based reference model checked
// every cycle, plus directed vectors with hand-computed expectations.
module tb_ahb_slave;

    logic        Hclk = 1'b0;
    logic        Hresetn;
    logic        Hwrite;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic [31:0] Prdata;
    logic        valid;
    logic [31:0] Haddr1, Haddr2;
    logic [31:0] Hwdata1, Hwdata2;
    logic [31:0] Hrdata;
    logic        Hwritereg;
    logic [2:0]  tempselx;
    logic [1:0]  Hresp;

    int errors = 0;
    int checks = 0;
    bit running = 1'b0;

    ahb_slave #(.ADDR_W(32), .DATA_W(32)) dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Hwrite    (Hwrite),
        .Hreadyin  (Hreadyin),
        .Htrans    (Htrans),
        .Haddr     (Haddr),
        .Hwdata    (Hwdata),
        .Prdata    (Prdata),
        .valid     (valid),
        .Haddr1    (Haddr1),
        .Haddr2    (Haddr2),
        .Hwdata1   (Hwdata1),
        .Hwdata2   (Hwdata2),
        .Hrdata    (Hrdata),
        .Hwritereg (Hwritereg),
        .tempselx  (tempselx),
        .Hresp     (Hresp)
    );

    always #5 Hclk = ~Hclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a log of what was on the bus at each clock edge since reset.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
    } beat_t;

    beat_t hist[$];

    always @(negedge Hresetn) hist.delete();

    always @(posedge Hclk) begin
        if (Hresetn === 1'b1) begin
            hist.push_front('{addr: Haddr, wdata: Hwdata, write: Hwrite});
            if (hist.size() > 2) void'(hist.pop_back());
        end
    end

    function automatic logic [2:0] model_sel(input logic [31:0] a);
        if (a < 32'h8000_0000 || a >= 32'h8C00_0000) return 3'b000;
        return 3'(1 << ((a - 32'h8000_0000) / 32'h0400_0000));
    endfunction

    function automatic logic model_valid(input logic [31:0] a, input logic rdy, input logic [1:0] tr);
        return rdy && (tr == 2'b10 || tr == 2'b11) && a >= 32'h8000_0000 && a < 32'h8C00_0000;
    endfunction

    always @(negedge Hclk) begin
        if (running) begin
            check("m_valid",    valid,     model_valid(Haddr, Hreadyin, Htrans));
            check("m_tempselx", tempselx,  model_sel(Haddr));
            check("m_hrdata",   Hrdata,    Prdata);
            check("m_hresp",    Hresp,     2'b00);
            check("m_haddr1",   Haddr1,    hist.size() > 0 ? hist[0].addr  : 32'h0);
            check("m_hwdata1",  Hwdata1,   hist.size() > 0 ? hist[0].wdata : 32'h0);
            check("m_hwritereg",Hwritereg, hist.size() > 0 ? hist[0].write : 1'b0);
            check("m_haddr2",   Haddr2,    hist.size() > 1 ? hist[1].addr  : 32'h0);
            check("m_hwdata2",  Hwdata2,   hist.size() > 1 ? hist[1].wdata : 32'h0);
        end
    end

    // Apply a bus pattern shortly after a rising edge, then wait to mid-cycle.
    task automatic drive(input logic w, input logic rdy, input logic [1:0] tr,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] prd);
        @(posedge Hclk);
        #2;
        Hwrite   = w;
        Hreadyin = rdy;
        Htrans   = tr;
        Haddr    = a;
        Hwdata   = wd;
        Prdata   = prd;
        @(negedge Hclk);
    endtask

    initial begin
        Hresetn  = 1'b0;
        Hwrite   = 1'b1;
        Hreadyin = 1'b1;
        Htrans   = 2'b10;
        Haddr    = 32'h8000_0000;
        Hwdata   = 32'h1234_5678;
        Prdata   = 32'h0;
        running  = 1'b1;

        // Reset held across several edges: registers stay zero, decode still live.
        repeat (3) @(negedge Hclk);
        check("rst_haddr1",    Haddr1,    32'h0);
        check("rst_haddr2",    Haddr2,    32'h0);
        check("rst_hwdata1",   Hwdata1,   32'h0);
        check("rst_hwdata2",   Hwdata2,   32'h0);
        check("rst_hwritereg", Hwritereg, 1'b0);
        check("rst_valid",     valid,     1'b1);
        check("rst_tempselx",  tempselx,  3'b001);

        @(posedge Hclk);
        #2 Hresetn = 1'b1;

        // Write NONSEQ, then read SEQ, then idle.
        drive(1'b1, 1'b1, 2'b10, 32'h8000_0000, 32'h1234_5678, 32'h0);
        check("wr_valid",    valid,    1'b1);
        check("wr_tempselx", tempselx, 3'b001);
        drive(1'b0, 1'b1, 2'b11, 32'h8400_0000, 32'hAAAA_5555, 32'h8765_4321);
        check("wr_haddr1",    Haddr1,    32'h8000_0000);
        check("wr_hwdata1",   Hwdata1,   32'h1234_5678);
        check("wr_hwritereg", Hwritereg, 1'b1);
        check("rd_valid",     valid,     1'b1);
        check("rd_tempselx",  tempselx,  3'b010);
        check("rd_hrdata",    Hrdata,    32'h8765_4321);
        drive(1'b0, 1'b1, 2'b00, 32'h8800_0000, 32'h0BAD_F00D, 32'h0);
        check("wr_haddr2",    Haddr2,    32'h8000_0000);
        check("wr_hwdata2",   Hwdata2,   32'h1234_5678);
        check("rd_hwritereg", Hwritereg, 1'b0);
        check("rd_haddr1",    Haddr1,    32'h8400_0000);

        // Decode sweep including window edges.
        drive(1'b1, 1'b1, 2'b10, 32'h8800_0000, 32'h1111_1111, 32'h0);
        check("sw_8800_sel", tempselx, 3'b100);
        check("sw_8800_vld", valid,    1'b1);
        drive(1'b1, 1'b1, 2'b10, 32'h8C00_0000, 32'h2222_2222, 32'h0);
        check("sw_8C00_sel", tempselx, 3'b000);
        check("sw_8C00_vld", valid,    1'b0);
        drive(1'b1, 1'b1, 2'b10, 32'h7FFF_FFFF, 32'h3333_3333, 32'h0);
        check("sw_7FFF_sel", tempselx, 3'b000);
        check("sw_7FFF_vld", valid,    1'b0);
        drive(1'b1, 1'b1, 2'b11, 32'h8BFF_FFFF, 32'h4444_4444, 32'h0);
        check("sw_8BFF_sel", tempselx, 3'b100);
        check("sw_8BFF_vld", valid,    1'b1);
        drive(1'b0, 1'b1, 2'b11, 32'h83FF_FFFF, 32'h5555_5555, 32'h0);
        check("sw_83FF_sel", tempselx, 3'b001);
        drive(1'b0, 1'b1, 2'b11, 32'h87FF_FFFF, 32'h6666_6666, 32'h0);
        check("sw_87FF_sel", tempselx, 3'b010);

        // Qualification: IDLE, BUSY, not-ready all suppress valid only.
        drive(1'b1, 1'b1, 2'b00, 32'h8000_0000, 32'h7777_7777, 32'h0);
        check("q_idle_vld", valid,    1'b0);
        check("q_idle_sel", tempselx, 3'b001);
        drive(1'b1, 1'b1, 2'b01, 32'h8000_0004, 32'h8888_8888, 32'h0);
        check("q_busy_vld", valid,    1'b0);
        check("q_busy_sel", tempselx, 3'b001);
        check("q_busy_a1",  Haddr1,   32'h8000_0000);
        drive(1'b1, 1'b0, 2'b10, 32'h8000_0008, 32'h9999_9999, 32'h0);
        check("q_nrdy_vld", valid,    1'b0);
        check("q_nrdy_sel", tempselx, 3'b001);
        check("q_nrdy_a1",  Haddr1,   32'h8000_0004);
        drive(1'b1, 1'b1, 2'b10, 32'h8000_000C, 32'hCAFE_0000, 32'h0);
        check("q_nrdy_a1b", Haddr1,   32'h8000_0008);

        // Mid-transfer reset: clears immediately, capture resumes on the next edge.
        @(posedge Hclk);
        #2 Hresetn = 1'b0;
        #1;
        check("mr_haddr1_async", Haddr1, 32'h0);
        @(negedge Hclk);
        check("mr_hwdata2", Hwdata2, 32'h0);
        check("mr_valid",   valid,   1'b1);
        @(posedge Hclk);
        #2 Hresetn = 1'b1;
        @(negedge Hclk);
        check("mr_hold_a1", Haddr1, 32'h0);
        drive(1'b0, 1'b1, 2'b11, 32'h8400_0010, 32'hDEAD_BEEF, 32'h0);
        check("mr_resume_a1", Haddr1,  32'h8000_000C);
        check("mr_resume_a2", Haddr2,  32'h0);
        drive(1'b0, 1'b1, 2'b00, 32'h0000_0000, 32'h0, 32'h0);
        check("mr_resume_w1", Hwdata1, 32'hDEAD_BEEF);
        check("mr_resume_a2b", Haddr2, 32'h8000_000C);

        repeat (2) @(negedge Hclk);
        running = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
